// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 op encodings, multiply/divide FSM states and
// operand-signedness helpers used by the muldiv unit and its bench.
package riscv_m_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the issuing pipeline and the muldiv unit.
interface muldiv_unit_if;
  import riscv_m_pkg::*;

  // Handshake: start is taken on a rising edge only while busy=0 (IDLE or DONE);
  // done is a one-cycle pulse, and result/rd_out stay put until the next accepted start.
  logic         start;
  logic [2:0]   op;
  logic [31:0]  a;
  logic [31:0]  b;
  logic [4:0]   rd_in;
  logic         busy;
  logic         done;
  logic [31:0]  result;
  logic [4:0]   rd_out;
  logic         we_out;
  logic         illegal_op;
  state_e       dbg_state;

  modport master (
    output start, op, a, b, rd_in,
    input  busy, done, result, rd_out, we_out, illegal_op, dbg_state
  );

  modport slave (
    input  start, op, a, b, rd_in,
    output busy, done, result, rd_out, we_out, illegal_op, dbg_state
  );

endinterface

// File: rtl/div_restoring.sv
// Unsigned 32-step restoring divider: load magnitudes, then one quotient bit per i_step.
module div_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Partial remainder stays below the divisor, so one extra bit holds the trial borrow.
  always_comb begin
    w_shift = {r_r, r_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_d};
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_q <= i_dividend;
      r_r <= '0;
      r_d <= i_divisor;
    end else if (i_step) begin
      if (!w_diff[WIDTH]) begin
        r_r <= w_diff[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= w_shift[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quot = r_q;
  assign o_rem  = r_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Divide datapath present only with macro RV32M_DIV_EN; without it divide ops finish as illegal_op.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  state_e               r_state, w_next;
  logic                 w_accept, w_finish, w_busy, w_done, w_last;
  logic [2:0]           r_op;
  logic [4:0]           r_rd;
  logic [5:0]           r_cnt;
  logic                 r_neg_q, r_illegal, w_illegal_fin;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b, r_mlt, r_result, w_final;
  logic [2*WIDTH-1:0]   r_prod, r_mcand, w_prod_fix;

  always_comb begin
    w_a_neg = op_a_signed(bus.op) & bus.a[WIDTH-1];
    w_b_neg = op_b_signed(bus.op) & bus.b[WIDTH-1];
    w_mag_a = w_a_neg ? -bus.a : bus.a;
    w_mag_b = w_b_neg ? -bus.b : bus.b;
  end

`ifdef RV32M_DIV_EN
  logic [WIDTH-1:0] r_a, r_b, w_quot, w_rem;
  logic             r_neg_r, w_div0, w_ovf;

  // Zero divisor and signed overflow finish on the first cycle without iterating.
  assign w_div0 = (r_b == '0);
  assign w_ovf  = !r_op[0] && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
  assign w_last = (r_cnt == 6'd32) || ((r_cnt == 6'd0) && (w_div0 || w_ovf));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_neg_r <= w_a_neg;
    end
  end

  div_restoring #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .i_load     (w_accept),
    .i_step     ((r_state == S_DIV) && !r_cnt[5]),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );
`else
  assign w_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        w_next = S_IDLE;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = bus.op[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        w_busy = 1'b1;
        if (r_cnt == 6'd32) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DIV: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd      <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_rd      <= bus.rd_in;
        r_illegal <= 1'b0;
        r_cnt     <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_finish) begin
        r_result  <= w_final;
        r_illegal <= w_illegal_fin;
      end
    end
  end

  // Multiplicand shifts left while the multiplier shifts right; 64-bit sum needs no carry-out.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= bus.op;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_prod  <= '0;
      r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
      r_mlt   <= w_mag_b;
    end else if (r_state == S_MUL) begin
      if (r_mlt[0]) r_prod <= r_prod + r_mcand;
      r_mcand <= r_mcand << 1;
      r_mlt   <= r_mlt >> 1;
    end
  end

  always_comb begin
    w_final       = '0;
    w_illegal_fin = 1'b0;
    w_prod_fix    = r_neg_q ? -r_prod : r_prod;
    if (!r_op[2]) begin
      w_final = (r_op[1:0] == 2'b00) ? w_prod_fix[WIDTH-1:0] : w_prod_fix[2*WIDTH-1:WIDTH];
    end else begin
`ifdef RV32M_DIV_EN
      if (w_div0)       w_final = r_op[1] ? r_a : '1;
      else if (w_ovf)   w_final = r_op[1] ? '0 : r_a;
      else if (r_op[1]) w_final = r_neg_r ? -w_rem : w_rem;
      else              w_final = r_neg_q ? -w_quot : w_quot;
`else
      w_illegal_fin = 1'b1;
`endif
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.result     = r_result;
  assign bus.rd_out     = r_rd;
  assign bus.we_out     = w_done && (r_rd != 5'd0) && !r_illegal;
  assign bus.illegal_op = w_done && r_illegal;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every cycle,
// plus hand-computed results and latencies for the listed vectors.
module tb_muldiv_unit;
  import riscv_m_pkg::*;

`ifdef RV32M_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_unit_if bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    int          ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // ---------------- reference model ----------------
  bit          m_armed = 1'b0;
  bit          m_busy, m_done, m_illegal, m_pend_ill;
  int          m_cnt;
  logic [31:0] m_result, m_pend;
  logic [4:0]  m_rd;

  always @(posedge clk) begin
    if (reset) begin
      m_armed   = 1'b1;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_cnt     = 0;
      m_result  = '0;
      m_rd      = '0;
      m_illegal = 1'b0;
    end else if (!m_busy && bus.start) begin
      m_done = 1'b0;
      m_busy = 1'b1;
      m_rd   = bus.rd_in;
      if (bus.op[2] && !DIV_EN) begin
        m_pend     = '0;
        m_pend_ill = 1'b1;
        m_cnt      = 1;
      end else begin
        m_pend     = ref_result(bus.op, bus.a, bus.b);
        m_pend_ill = 1'b0;
        m_cnt      = (bus.op[2] && (bus.b == 32'd0 ||
                      (!bus.op[0] && bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF))) ? 1 : 33;
      end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy    = 1'b0;
        m_done    = 1'b1;
        m_result  = m_pend;
        m_illegal = m_pend_ill;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_armed) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("we_out", bus.we_out, m_done && (m_rd != 5'd0) && !m_illegal);
      check("illegal_op", bus.illegal_op, m_done && m_illegal);
      if (!m_busy) begin
        check("result", bus.result, m_result);
        check("rd_out", bus.rd_out, m_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [4:0] rd_i, input logic [31:0] exp_res, input int exp_lat,
                        input logic exp_we, input logic exp_ill, input bit repulse,
                        input string name);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.rd_in = rd_i;
    @(posedge clk);
    @(negedge clk);
    bus.op    = 3'($urandom_range(0, 7));
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.rd_in = 5'($urandom_range(0, 31));
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      bus.start = (repulse && k == 4) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check({name, "_latency"}, k, exp_lat);
    check({name, "_result"}, bus.result, exp_res);
    check({name, "_we_out"}, bus.we_out, exp_we);
    check({name, "_illegal"}, bus.illegal_op, exp_ill);
    check({name, "_rd_out"}, bus.rd_out, rd_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_done, t_first, t_second, k;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_out", bus.rd_out, 5'd0);
    reset = 1'b0;

    run_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b1, 1'b0, 1'b0, "mul_7_m3");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, 1'b1, 1'b0, 1'b0, "mulhu_max");
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 33, 1'b1, 1'b0, 1'b0, "mulh_m1");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd6, 32'hFFFF_FFFF, 33, 1'b1, 1'b0, 1'b0, "mulhsu_m1_2");
    run_op(OP_MUL,    32'h1234_5678, 32'h10,        5'd7, 32'h2345_6780, 33, 1'b1, 1'b0, 1'b1, "mul_repulse");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, 33, 1'b1, 1'b0, 1'b0, "mulh_minsq");

    run_op(OP_DIV,  32'hFFFF_FFEC, 32'd6, 5'd10, DIV_EN ? 32'hFFFF_FFFD : 32'd0, DIV_EN ? 33 : 1,
           DIV_EN, !DIV_EN, 1'b0, "div_m20_6");
    run_op(OP_REM,  32'hFFFF_FFEC, 32'd6, 5'd11, DIV_EN ? 32'hFFFF_FFFE : 32'd0, DIV_EN ? 33 : 1,
           DIV_EN, !DIV_EN, 1'b0, "rem_m20_6");
    run_op(OP_DIVU, 32'd100, 32'd0, 5'd12, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1,
           DIV_EN, !DIV_EN, 1'b0, "divu_by0");
    run_op(OP_REM,  32'd100, 32'd0, 5'd13, DIV_EN ? 32'd100 : 32'd0, 1,
           DIV_EN, !DIV_EN, 1'b0, "rem_by0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, DIV_EN ? 32'h8000_0000 : 32'd0, 1,
           DIV_EN, !DIV_EN, 1'b0, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1,
           DIV_EN, !DIV_EN, 1'b0, "rem_ovf");
    run_op(OP_DIVU, 32'hFFFF_FFF0, 32'd3, 5'd16, DIV_EN ? 32'h5555_5550 : 32'd0, DIV_EN ? 33 : 1,
           DIV_EN, !DIV_EN, 1'b1, "divu_big");
    run_op(OP_REMU, 32'hFFFF_FFF2, 32'd3, 5'd17, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 33 : 1,
           DIV_EN, !DIV_EN, 1'b0, "remu_big");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, DIV_EN ? 33 : 1,
           DIV_EN, !DIV_EN, 1'b0, "divu_no_ovf");

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.rd_in = 5'd2;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rst_prio_busy", bus.busy, 1'b0);

    // Reset at edge 10 of a multiply aborts it silently.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    bus.rd_in = 5'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.we_out) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_op(OP_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 33, 1'b0, 1'b0, 1'b0, "mul_rd0");

    // Start held high: k counts edges with the accepting edge as k=1.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd9;
    bus.b     = 32'd11;
    bus.rd_in = 5'd12;
    t_first   = -1;
    t_second  = -1;
    k         = 0;
    while (t_second < 0 && k < 200) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (bus.done === 1'b1) begin
        if (t_first < 0) t_first = k;
        else             t_second = k;
      end
    end
    bus.start = 1'b0;
    check("b2b_first_done", t_first, 34);
    check("b2b_gap", t_second - t_first, 34);
    check("b2b_result", bus.result, 32'd99);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 supported.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port: op  input  3  RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-006 SHALL have port: a  input  32  rs1 operand, fed from register-file rd1.
REQ-007 SHALL have port: b  input  32  rs2 operand, fed from register-file rd2.
REQ-008 SHALL have port: rd_in  input  5  destination register index.
REQ-009 SHALL have port: busy  output  1  operation in flight.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: result  output  32  result, drives register-file wd3.
REQ-012 SHALL have port: rd_out  output  5  captured rd_in, drives register-file a3.
REQ-013 SHALL have port: we_out  output  1  write strobe, drives register-file we3.
REQ-014 SHALL have port: illegal_op  output  1  op unsupported in this build; valid with done.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE: IDLE/DONE + start -> MUL (op[2]=0) or DIV (op[2]=1); MUL/DIV -> DONE after 32 iterations; DONE -> IDLE without start.
REQ-016 SHALL capture op, a, b, rd_in on the start-sampling edge; later input changes have no effect.
REQ-017 SHALL run one radix-2 step per cycle: shift-add multiply, restoring divide, on operand magnitudes, sign-correcting the 64-bit product or quotient/remainder at completion.
REQ-018 SHALL assert done, and capture result, for exactly one cycle after edge 33 (start-sampling edge = edge 0).
REQ-019 SHALL return product[31:0] for MUL and product[63:32] for MULH (s*s), MULHSU (s*u), MULHU (u*u).
REQ-020 SHALL fast-path divide by zero: done after edge 1; DIV/DIVU = 32'hFFFF_FFFF, REM/REMU = a.
REQ-021 SHALL fast-path signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF): done after edge 1; DIV = 32'h8000_0000, REM = 0.
REQ-022 SHALL hold busy=1 in MUL/DIV and busy=0 in IDLE/DONE.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL accept start in DONE, giving back-to-back operation with no IDLE cycle.
REQ-025 SHALL drive we_out = done AND (rd_out != 0); x0 is never written.
REQ-026 SHALL hold result and rd_out stable from done until the next accepted start.

Reset
REQ-027 SHALL, on reset at any edge, force IDLE and drive busy, done, we_out, illegal_op, result, rd_out to 0.
REQ-028 SHALL discard an operation aborted by reset, with no we_out pulse.
REQ-029 SHALL take reset priority over a simultaneous start.

Configuration
REQ-030 SHALL compile the divider datapath only when macro RV32M_DIV_EN is defined.
REQ-031 SHALL, with RV32M_DIV_EN undefined, complete any op[2]=1 request after edge 1 with result=0, illegal_op=1, we_out=0; multiply behaviour unchanged.

Structure
REQ-032 SHALL take op encodings and the state enum from shared package riscv_m_pkg.
REQ-033 SHALL place the 32-step restoring divider in sub-module div_restoring, instantiated only under RV32M_DIV_EN.

Verification
REQ-034 SHALL cover: MUL a=7, b=-3 -> done after edge 33, result=32'hFFFF_FFEB, we_out=1 with rd_out=5.
REQ-035 SHALL cover: MULHU a=b=32'hFFFF_FFFF -> result=32'hFFFF_FFFE; MULH same operands -> 0.
REQ-036 SHALL cover: DIV a=-20, b=6 -> -3; REM -> -2; DIVU a=100, b=0 -> 32'hFFFF_FFFF after edge 1.
REQ-037 SHALL cover: DIV a=32'h8000_0000, b=-1 -> 32'h8000_0000; start re-pulsed mid-operation is ignored.
REQ-038 SHALL cover: reset at edge 10 of a MUL -> busy=0, no done/we_out; new start at rd_in=0 -> done with we_out=0.
REQ-039 SHALL cover: start held high across DONE -> second op accepted, done pulses 34 cycles apart.
